// File: rtl/instruction_encoder_if.sv
// Request/response stream bundle for instruction_encoder.
// master = request producer and word consumer, slave = the encoder.
interface instruction_encoder_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [2:0]  SELECTION;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [63:0] IMM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTRUCTION;
    logic        OUT_ERR;

    modport master (
        output IN_VALID, SELECTION, OPCODE, FUNCT3, RD, RS1, RS2, IMM, OUT_READY,
        input  IN_READY, OUT_VALID, INSTRUCTION, OUT_ERR
    );

    modport slave (
        input  IN_VALID, SELECTION, OPCODE, FUNCT3, RD, RS1, RS2, IMM, OUT_READY,
        output IN_READY, OUT_VALID, INSTRUCTION, OUT_ERR
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs instruction fields and a signed 64-bit immediate into an RV64 word (I/U/S/B/J).
// Define INSTRUCTION_ENCODER_LI_EXPAND_EN to enable the two-word LUI+ADDIW load-immediate.
//
// state | meaning
// EMPTY | no word held, request accepted unconditionally
// FULL  | one word held on the output
// PEND  | first LI word (LUI) held, ADDIW word owed next
module instruction_encoder (
    input  logic                  CLK,
    input  logic                  RST_N,
    instruction_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY,
        FULL
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
        , PEND
`endif
    } state_t;

    state_t      state;
    logic [63:0] imm;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        fits32;
    logic        accept;
    logic [31:0] enc_word;
    logic        enc_err;

`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
    logic [31:0] enc_word2;
    logic        enc_two;
    logic [19:0] li_hi;
    logic [31:0] pend_word;
`endif

    assign imm = bus.IMM;

    // A value fits in N signed bits when every bit from N-1 upward equals the sign.
    assign fits12 = (&imm[63:11]) | ~(|imm[63:11]);
    assign fits13 = (&imm[63:12]) | ~(|imm[63:12]);
    assign fits21 = (&imm[63:20]) | ~(|imm[63:20]);
    assign fits32 = (&imm[63:31]) | ~(|imm[63:31]);

    assign bus.IN_READY = (state == EMPTY) || ((state == FULL) && bus.OUT_READY);
    assign accept       = bus.IN_VALID && bus.IN_READY;

`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
    // Rounding by 0x800 compensates for ADDIW sign-extending its 12-bit lo part.
    assign li_hi = imm[31:12] + {19'd0, imm[11]};
`endif

    always_comb begin
        enc_word = 32'd0;
        enc_err  = 1'b0;
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
        enc_word2 = 32'd0;
        enc_two   = 1'b0;
`endif
        case (bus.SELECTION)
            3'd1: begin
                if (fits12)
                    enc_word = {imm[11:0], bus.RS1, bus.FUNCT3, bus.RD, bus.OPCODE};
                else
                    enc_err = 1'b1;
            end
            3'd2: begin
                if (fits32 && (imm[11:0] == 12'd0))
                    enc_word = {imm[31:12], bus.RD, bus.OPCODE};
                else
                    enc_err = 1'b1;
            end
            3'd3: begin
                if (fits12)
                    enc_word = {imm[11:5], bus.RS2, bus.RS1, bus.FUNCT3, imm[4:0], bus.OPCODE};
                else
                    enc_err = 1'b1;
            end
            3'd4: begin
                if (fits13 && !imm[0])
                    enc_word = {imm[12], imm[10:5], bus.RS2, bus.RS1, bus.FUNCT3,
                                imm[4:1], imm[11], bus.OPCODE};
                else
                    enc_err = 1'b1;
            end
            3'd5: begin
                if (fits21 && !imm[0])
                    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.RD, bus.OPCODE};
                else
                    enc_err = 1'b1;
            end
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
            3'd6: begin
                if (!fits32) begin
                    enc_err = 1'b1;
                end else if (li_hi != 20'd0) begin
                    enc_word  = {li_hi, bus.RD, 7'b0110111};
                    enc_word2 = {imm[11:0], bus.RD, 3'b000, bus.RD, 7'b0011011};
                    enc_two   = 1'b1;
                end else begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, bus.RD, 7'b0010011};
                end
            end
`endif
            default: enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= EMPTY;
            bus.OUT_VALID   <= 1'b0;
            bus.INSTRUCTION <= 32'd0;
            bus.OUT_ERR     <= 1'b0;
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
            pend_word       <= 32'd0;
`endif
        end else if (accept) begin
            bus.OUT_VALID   <= 1'b1;
            bus.INSTRUCTION <= enc_word;
            bus.OUT_ERR     <= enc_err;
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
            pend_word       <= enc_word2;
            state           <= enc_two ? PEND : FULL;
`else
            state           <= FULL;
`endif
        end else if (bus.OUT_VALID && bus.OUT_READY) begin
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
            if (state == PEND) begin
                bus.INSTRUCTION <= pend_word;
                bus.OUT_ERR     <= 1'b0;
                state           <= FULL;
            end else
`endif
            begin
                bus.OUT_VALID <= 1'b0;
                state         <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed test-plan vectors plus a
// randomized stream scored against a queue-based reference model.
module tb_instruction_encoder;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    instruction_encoder_if bus ();

    instruction_encoder dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: returns the 1 or 2 words ({err, word}) a request produces.
    function automatic void model(input logic [2:0] sel, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input longint imm, output int n,
                                  output logic [32:0] r0, output logic [32:0] r1);
        logic [63:0] u;
        bit          ok;
        logic [31:0] w;
        longint      t;
        logic [19:0] hi;
        u  = imm;
        ok = 1'b0;
        w  = 32'd0;
        n  = 1;
        r1 = 33'd0;
        case (sel)
            3'd1: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = {u[11:0], rs1, f3, rd, op};
            end
            3'd2: begin
                ok = (imm >= -(longint'(1) << 31)) && (imm <= (longint'(1) << 31) - 4096)
                     && (u[11:0] == 12'd0);
                w  = {u[31:12], rd, op};
            end
            3'd3: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = {u[11:5], rs2, rs1, f3, u[4:0], op};
            end
            3'd4: begin
                ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                w  = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
            end
            3'd5: begin
                ok = (imm >= -(longint'(1) << 20)) && (imm <= (longint'(1) << 20) - 2)
                     && (imm % 2 == 0);
                w  = {u[20], u[10:1], u[11], u[19:12], rd, op};
            end
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
            3'd6: begin
                ok = (imm >= -(longint'(1) << 31)) && (imm <= (longint'(1) << 31) - 1);
                t  = (imm + 2048) >>> 12;
                hi = t[19:0];
                if (hi != 20'd0) begin
                    w  = {hi, rd, 7'b0110111};
                    r1 = {1'b0, u[11:0], rd, 3'b000, rd, 7'b0011011};
                    if (ok) n = 2;
                end else begin
                    w = {u[11:0], 5'd0, 3'b000, rd, 7'b0010011};
                end
            end
`endif
            default: ok = 1'b0;
        endcase
        if (ok)
            r0 = {1'b0, w};
        else begin
            r0 = {1'b1, 32'd0};
            n  = 1;
        end
    endfunction

    function automatic longint rand_imm();
        longint v;
        case ($urandom_range(0, 4))
            0:       v = longint'($urandom_range(0, 8400)) - 4200;
            1:       v = {$urandom, $urandom};
            2:       v = longint'(int'($urandom));
            3:       v = longint'(int'($urandom & 32'hFFFFF000));
            default: v = longint'($urandom_range(0, 32'h400000)) - 64'sh200000;
        endcase
        if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
        return v;
    endfunction

    task automatic set_req(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input longint imm);
        bus.SELECTION = sel;
        bus.OPCODE    = op;
        bus.FUNCT3    = f3;
        bus.RD        = rd;
        bus.RS1       = rs1;
        bus.RS2       = rs2;
        bus.IMM       = imm;
    endtask

    // Presents a request and returns just after the edge that accepts it.
    task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input longint imm);
        bit ok;
        set_req(sel, op, f3, rd, rs1, rs2, imm);
        bus.IN_VALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (bus.IN_READY) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: IN_READY=%0b after 20 cycles, required 1", bus.IN_READY);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST_N         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        set_req(3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 0);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.INSTRUCTION !== 32'd0 || bus.OUT_ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b instr=%h err=%b, required 0/00000000/0",
                     bus.OUT_VALID, bus.INSTRUCTION, bus.OUT_ERR);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.IN_READY);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        longint      imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    task automatic test_vectors();
        vec_t v[$];
        v.push_back('{3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, -1,          32'hFFF00093, 1'b0});
        v.push_back('{3'd4, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, -4,          32'hFE000EE3, 1'b0});
        v.push_back('{3'd4, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 3,           32'h00000000, 1'b1});
        v.push_back('{3'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 2048,        32'h001000EF, 1'b0});
        v.push_back('{3'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 1 << 20,     32'h00000000, 1'b1});
        v.push_back('{3'd3, 7'h23, 3'd3, 5'd0, 5'd2, 5'd8, -8,          32'hFE813C23, 1'b0});
        v.push_back('{3'd2, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0});
        v.push_back('{3'd2, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345001, 32'h00000000, 1'b1});
        v.push_back('{3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 2048,        32'h00000000, 1'b1});
        v.push_back('{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 0,           32'h00000000, 1'b1});
        v.push_back('{3'd7, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 0,           32'h00000000, 1'b1});
        bus.OUT_READY = 1'b1;
        foreach (v[i]) begin
            send(v[i].sel, v[i].op, v[i].f3, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.INSTRUCTION !== v[i].word || bus.OUT_ERR !== v[i].err) begin
                failures++;
                $display("FAIL vector%0d: valid=%b instr=%h err=%b, required 1/%h/%b",
                         i, bus.OUT_VALID, bus.INSTRUCTION, bus.OUT_ERR, v[i].word, v[i].err);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL vector%0d_drain: valid=%b, required 0", i, bus.OUT_VALID);
            end
        end
    endtask

    task automatic test_li();
        int n;
        logic [32:0] r0, r1;
        longint imm;
        imm = 64'h12345FFF;
        model(3'd6, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, imm, n, r0, r1);
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
        checks++;
        if (n != 2 || r0 !== {1'b0, 32'h123462B7} || r1 !== {1'b0, 32'hFFF2829B}) begin
            failures++;
            $display("FAIL li_model: n=%0d w0=%h w1=%h, required 2/123462B7/FFF2829B", n, r0, r1);
        end
`endif
        bus.OUT_READY = 1'b0;
        send(3'd6, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, imm);
        repeat (3) begin
            checks++;
            if (bus.OUT_VALID !== 1'b1 || {bus.OUT_ERR, bus.INSTRUCTION} !== r0) begin
                failures++;
                $display("FAIL li_hold: valid=%b word=%h, required 1/%h",
                         bus.OUT_VALID, {bus.OUT_ERR, bus.INSTRUCTION}, r0);
            end
            @(negedge CLK);
            checks++;
            if (bus.IN_READY !== 1'b0) begin
                failures++;
                $display("FAIL li_hold_ready: IN_READY=%b, required 0", bus.IN_READY);
            end
            @(posedge CLK);
            #1;
        end
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== (n == 1)) begin
            failures++;
            $display("FAIL li_drain_ready: IN_READY=%b, required %b", bus.IN_READY, n == 1);
        end
        @(posedge CLK);
        #1;
        if (n == 2) begin
            checks++;
            if (bus.OUT_VALID !== 1'b1 || {bus.OUT_ERR, bus.INSTRUCTION} !== r1) begin
                failures++;
                $display("FAIL li_second: valid=%b word=%h, required 1/%h",
                         bus.OUT_VALID, {bus.OUT_ERR, bus.INSTRUCTION}, r1);
            end
            @(posedge CLK);
            #1;
        end
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL li_end: valid=%b, required 0", bus.OUT_VALID);
        end
        model(3'd6, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 5, n, r0, r1);
        send(3'd6, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 5);
`ifdef INSTRUCTION_ENCODER_LI_EXPAND_EN
        checks++;
        if (bus.INSTRUCTION !== 32'h00500293 || bus.OUT_ERR !== 1'b0) begin
            failures++;
            $display("FAIL li_small: instr=%h err=%b, required 00500293/0", bus.INSTRUCTION, bus.OUT_ERR);
        end
`else
        checks++;
        if (bus.INSTRUCTION !== 32'd0 || bus.OUT_ERR !== 1'b1) begin
            failures++;
            $display("FAIL li_disabled: instr=%h err=%b, required 00000000/1", bus.INSTRUCTION, bus.OUT_ERR);
        end
`endif
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL li_small_single: valid=%b, required 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [32:0] r0, r1;
        longint imm;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imm = longint'($urandom_range(0, 4095)) - 2048;
            set_req(3'd1, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'd0, imm);
            model(bus.SELECTION, bus.OPCODE, bus.FUNCT3, bus.RD, bus.RS1, bus.RS2, imm, n, r0, r1);
            @(negedge CLK);
            checks++;
            if (bus.IN_READY !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready%0d: IN_READY=%b, required 1", i, bus.IN_READY);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b1 || {bus.OUT_ERR, bus.INSTRUCTION} !== r0) begin
                failures++;
                $display("FAIL b2b_word%0d: valid=%b word=%h, required 1/%h",
                         i, bus.OUT_VALID, {bus.OUT_ERR, bus.INSTRUCTION}, r0);
            end
        end
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_in_pend();
        bus.OUT_READY = 1'b0;
        send(3'd6, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h12345FFF);
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.INSTRUCTION !== 32'd0 || bus.OUT_ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_pend: valid=%b instr=%h err=%b, required 0/00000000/0",
                     bus.OUT_VALID, bus.INSTRUCTION, bus.OUT_ERR);
        end
        @(negedge CLK);
        RST_N         = 1'b1;
        bus.OUT_READY = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL reset_pend_after: valid=%b instr=%h, required no word",
                         bus.OUT_VALID, bus.INSTRUCTION);
            end
        end
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        int n;
        logic [32:0] r0, r1;
        logic exp_ready;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge CLK);
            #1;
            set_req(3'($urandom), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), rand_imm());
            bus.IN_VALID  = ($urandom_range(0, 9) < 7);
            bus.OUT_READY = ($urandom_range(0, 9) < 7);
            @(negedge CLK);
            exp_ready = (q.size() == 0) || ((q.size() == 1) && bus.OUT_READY);
            checks++;
            if (bus.OUT_VALID !== (q.size() > 0) || bus.IN_READY !== exp_ready) begin
                failures++;
                $display("FAIL rand_flow%0d: valid=%b ready=%b, required %b/%b",
                         cyc, bus.OUT_VALID, bus.IN_READY, q.size() > 0, exp_ready);
            end
            if (q.size() > 0) begin
                checks++;
                if ({bus.OUT_ERR, bus.INSTRUCTION} !== q[0]) begin
                    failures++;
                    $display("FAIL rand_word%0d: word=%h, required %h",
                             cyc, {bus.OUT_ERR, bus.INSTRUCTION}, q[0]);
                end
                if (bus.OUT_READY) void'(q.pop_front());
            end
            if (bus.IN_VALID && exp_ready) begin
                model(bus.SELECTION, bus.OPCODE, bus.FUNCT3, bus.RD, bus.RS1, bus.RS2,
                      bus.IMM, n, r0, r1);
                q.push_back(r0);
                if (n == 2) q.push_back(r1);
            end
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_li();
        test_back_to_back();
        test_reset_in_pend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields and a signed 64-bit immediate back into a 32-bit RV64 instruction word. It covers the I, U, S, B and J immediate formats and, optionally, a two-word LUI+ADDIW load-immediate expansion. It is the inverse of the pipeline's immediate decoder. It feeds the test-program generator and the self-checking instruction memory loader through a valid/ready stream with one registered output stage.

## Interface
- No parameters; widths fixed by the ISA.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_VALID` in 1: request present.
- `IN_READY` out 1: request accepted on a cycle where `IN_VALID & IN_READY`.
- `SELECTION` in 3: 1=I, 2=U, 3=S, 4=B, 5=J, 6=LI (load-immediate pseudo); 0 and 7 are illegal.
- `OPCODE` in 7: opcode field. Ignored for LI.
- `FUNCT3` in 3: funct3 field, used by I/S/B. Ignored for LI.
- `RD` in 5, `RS1` in 5, `RS2` in 5: register fields. Only `RD` is used for LI.
- `IMM` in 64 (signed): immediate value to encode.
- `OUT_VALID` out 1: `INSTRUCTION`/`OUT_ERR` valid.
- `OUT_READY` in 1: consumer takes the word on a cycle where `OUT_VALID & OUT_READY`.
- `INSTRUCTION` out 32: encoded word.
- `OUT_ERR` out 1: request was illegal or its immediate was out of range; `INSTRUCTION` is 0 on that beat.

## Operation
- Encodings, with `imm` = `IMM`:
  - I: `{imm[11:0], RS1, FUNCT3, RD, OPCODE}`
  - U: `{imm[31:12], RD, OPCODE}`
  - S: `{imm[11:5], RS2, RS1, FUNCT3, imm[4:0], OPCODE}`
  - B: `{imm[12], imm[10:5], RS2, RS1, FUNCT3, imm[4:1], imm[11], OPCODE}`
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], RD, OPCODE}`
- Range checks, on the full 64-bit signed `IMM`; a failing check sets `OUT_ERR`:
  - I/S: -2048..2047.
  - U: -2^31..2^31-4096 with `imm[11:0]==0`.
  - B: -4096..4094, even.
  - J: -2^20..2^20-2, even.
  - LI: -2^31..2^31-1.
- LI split:
  - `lo = IMM[11:0]` (signed).
  - `hi = (IMM + 0x800) >> 12`, arithmetic shift, low 20 bits kept.
  - If `hi != 0`: emit LUI `{hi, RD, 7'b0110111}`, then ADDIW `{lo, RD, 3'b000, RD, 7'b0011011}`.
  - If `hi == 0`: emit the single word ADDI `{lo, 5'd0, 3'b000, RD, 7'b0010011}`.
- States:
  - EMPTY: no word held. `OUT_VALID=0`, `IN_READY=1`.
  - FULL: one word held. `OUT_VALID=1`, `IN_READY=OUT_READY` (accept in the same cycle the held word drains).
  - PEND: first LI word held, ADDIW still owed. `OUT_VALID=1`, `IN_READY=0`.
- Transitions:
  - EMPTY, accept, one-word result → FULL.
  - EMPTY, accept, two-word LI → PEND.
  - FULL, drain, no accept → EMPTY.
  - FULL, drain with simultaneous accept → FULL or PEND according to the new request.
  - FULL, no drain → FULL; output held stable.
  - PEND, drain → FULL, with the ADDIW word loaded.
  - PEND, no drain → PEND; output held stable.
- An error result is always a single word.

## Timing
- Reset: state EMPTY; `OUT_VALID=0`, `INSTRUCTION=0`, `OUT_ERR=0`; `IN_READY=1` once reset deasserts.
- Reset mid-operation discards the held word and any pending ADDIW.
- Latency: accept at edge N → word valid after edge N.
- An LI second word appears on the cycle after the first word drains.
- Sustained throughput: 1 word/cycle while `OUT_READY=1`.
- LI occupies 2 output cycles, with `IN_READY` low for one of them.
- While `OUT_VALID & !OUT_READY`, `INSTRUCTION` and `OUT_ERR` are held unchanged.
- Input fields are sampled only on the accept cycle.

## Configuration
- Macro: `INSTRUCTION_ENCODER_LI_EXPAND_EN`.
- Defined: SELECTION=6 behaves as above, and the PEND state exists.
- Undefined: SELECTION=6 is illegal and produces a single word 0 with `OUT_ERR=1`; the PEND state is not built.

## Test plan
- I: SELECTION=1, OPCODE=0x13, FUNCT3=0, RD=1, RS1=0, IMM=-1 → `INSTRUCTION=0xFFF00093`, `OUT_ERR=0`, one cycle after accept.
- B: SELECTION=4, OPCODE=0x63, RS1=RS2=0, IMM=-4 → `0xFE000EE3`. Same request with IMM=3 → `INSTRUCTION=0`, `OUT_ERR=1`.
- J: SELECTION=5, OPCODE=0x6F, RD=1, IMM=2048 → `0x001000EF`. Same with IMM=2^20 → `OUT_ERR=1`.
- LI (macro defined), RD=5, IMM=0x12345FFF:
  - Output is `0x123462B7`, then `0xFFF2829B`.
  - Hold `OUT_READY` low 3 cycles on the first word: value stays stable and `IN_READY` stays 0 until PEND drains.
  - With IMM=5 → single word `0x00500293`.
- Back-to-back I requests with `OUT_READY=1`: one word per cycle, `IN_READY` held high.
- Assert `RST_N` low while in PEND → outputs return to 0 immediately; no ADDIW word is emitted after release.
